// File: rtl/dl2_mem_arbiter_if.sv
// Bus bundle for dl2_mem_arbiter: upstream client request/response lanes plus the
// strobed sub-block memory port. The arbiter uses the slave view.
interface dl2_mem_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_BITS  = 32,
  parameter int BLOCK_BITS = 256,
  parameter int SUBBLOCKS  = 4,
  parameter int SUB_LOG2   = 2
);
  localparam int BEAT_BITS = BLOCK_BITS / SUBBLOCKS;

  logic [NUM_PORTS*ADDR_BITS-1:0]  c_addr;
  logic [NUM_PORTS-1:0]            c_en;
  logic [NUM_PORTS-1:0]            c_we;
  logic [NUM_PORTS*BLOCK_BITS-1:0] c_din;
  logic [BLOCK_BITS-1:0]           c_dout;
  logic [NUM_PORTS-1:0]            c_ready;
  logic [NUM_PORTS-1:0]            c_accepting;
  logic [ADDR_BITS-1:0]            addrD;
  logic                            enD;
  logic                            weD;
  logic [SUB_LOG2-1:0]             doutDstrobe;
  logic [BEAT_BITS-1:0]            doutD;
  logic [SUB_LOG2-1:0]             dinDstrobe;
  logic [BEAT_BITS-1:0]            dinD;
  logic                            readyD;
  logic                            accR;
  logic                            accW;

  modport slave (
    input  c_addr, c_en, c_we, c_din, dinDstrobe, dinD, readyD, accR, accW,
    output c_dout, c_ready, c_accepting, addrD, enD, weD, doutDstrobe, doutD
  );

  modport master (
    output c_addr, c_en, c_we, c_din, dinDstrobe, dinD, readyD, accR, accW,
    input  c_dout, c_ready, c_accepting, addrD, enD, weD, doutDstrobe, doutD
  );
endinterface

// File: rtl/dl2_mem_arbiter.sv
// Round-robin N-client block arbiter in front of a single sub-blocked memory port:
// writes leave as SUBBLOCKS strobed beats, reads are reassembled from strobed beats.
module dl2_mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_BITS  = 32,
  parameter int BLOCK_BITS = 256,
  parameter int SUBBLOCKS  = 4,
  parameter int SUB_LOG2   = 2
) (
  input logic               clk,
  input logic               reset,
  dl2_mem_arbiter_if.slave  bus
);
  localparam int BEAT_BITS = BLOCK_BITS / SUBBLOCKS;
  localparam int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] RD_REQ  = 3'd2;
  localparam logic [2:0] RD_DATA = 3'd3;
  localparam logic [2:0] RESP    = 3'd4;

  logic [2:0]            stateR;
  logic [PTR_W-1:0]      rrPtrR;
  logic [PTR_W-1:0]      gntR;
  logic                  isWriteR;
  logic [ADDR_BITS-1:0]  addrR;
  logic [BLOCK_BITS-1:0] blockR;
  logic [SUB_LOG2-1:0]   cntR;
  logic [SUBBLOCKS-1:0]  recvR;

  logic [NUM_PORTS-1:0]  reqS;
  logic [PTR_W-1:0]      gntS;
  logic                  foundS;
  logic [SUBBLOCKS-1:0]  recvS;

  assign reqS  = bus.c_en | bus.c_we;
  assign recvS = recvR | (SUBBLOCKS'(1) << bus.dinDstrobe);

  // Round-robin pick: first requester at or after rrPtrR, wrapping.
  always_comb begin
    int idx;
    foundS = 1'b0;
    gntS   = rrPtrR;
    idx    = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (int'(rrPtrR) + k) % NUM_PORTS;
      if (!foundS && reqS[idx]) begin
        foundS = 1'b1;
        gntS   = PTR_W'(idx);
      end else begin
        foundS = foundS;
      end
    end
  end

  // Transaction FSM with request capture, beat sequencing and read reassembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateR   <= IDLE;
      rrPtrR   <= '0;
      gntR     <= '0;
      isWriteR <= 1'b0;
      addrR    <= '0;
      blockR   <= '0;
      cntR     <= '0;
      recvR    <= '0;
    end else begin
      case (stateR)
        IDLE: begin
          if (foundS) begin
            gntR     <= gntS;
            addrR    <= bus.c_addr[gntS*ADDR_BITS +: ADDR_BITS];
            isWriteR <= bus.c_we[gntS];
            blockR   <= bus.c_we[gntS] ? bus.c_din[gntS*BLOCK_BITS +: BLOCK_BITS] : '0;
            cntR     <= '0;
            recvR    <= '0;
            stateR   <= bus.c_we[gntS] ? WR : RD_REQ;
          end
        end
        WR: begin
          if (bus.accW) begin
            cntR <= cntR + SUB_LOG2'(1);
            if (cntR == SUB_LOG2'(SUBBLOCKS - 1)) begin
              stateR <= RESP;
            end
          end
        end
        RD_REQ: begin
          if (bus.accR) begin
            stateR <= RD_DATA;
          end
        end
        RD_DATA: begin
          // Beats may arrive out of order or repeat; the last write to a slice wins.
          if (bus.readyD) begin
            blockR[bus.dinDstrobe*BEAT_BITS +: BEAT_BITS] <= bus.dinD;
            recvR <= recvS;
            if (&recvS) begin
              stateR <= RESP;
            end
          end
        end
        RESP: begin
          rrPtrR <= (gntR == PTR_W'(NUM_PORTS - 1)) ? '0 : gntR + PTR_W'(1);
          recvR  <= '0;
          cntR   <= '0;
          stateR <= IDLE;
        end
        default: begin
          stateR <= IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state only; reset forces everything low.
  always_comb begin
    bus.enD         = (stateR == RD_REQ);
    bus.weD         = (stateR == WR);
    bus.addrD       = '0;
    bus.doutDstrobe = '0;
    bus.doutD       = '0;
    bus.c_ready     = '0;
    bus.c_dout      = '0;
    bus.c_accepting = '0;
    if (stateR == WR || stateR == RD_REQ) begin
      bus.addrD = addrR;
    end else begin
      bus.addrD = '0;
    end
    if (stateR == WR) begin
      bus.doutDstrobe = cntR;
      bus.doutD       = blockR[cntR*BEAT_BITS +: BEAT_BITS];
    end else begin
      bus.doutDstrobe = '0;
      bus.doutD       = '0;
    end
    if (stateR == RESP) begin
      bus.c_ready = NUM_PORTS'(1) << gntR;
      bus.c_dout  = isWriteR ? '0 : blockR;
    end else begin
      bus.c_ready = '0;
      bus.c_dout  = '0;
    end
    if (stateR == IDLE && !reset) begin
      bus.c_accepting = '1;
    end else begin
      bus.c_accepting = '0;
    end
  end
endmodule

// File: tb/tb_dl2_mem_arbiter.sv
// Scoreboard bench for dl2_mem_arbiter (3 clients, 256-bit blocks, 4 beats of 64 bits).
module tb_dl2_mem_arbiter;
  localparam int NP = 3;

  typedef struct packed {
    logic [2:0]   rdy;
    logic [255:0] data;
  } sbEntry_t;

  logic clk;
  logic reset;
  int   vecCount;
  int   errCount;
  sbEntry_t sbQ[$];

  int          nBeats;
  int          beatStrb[8];
  logic [63:0] beatData[8];

  dl2_mem_arbiter_if #(.NUM_PORTS(NP), .ADDR_BITS(32), .BLOCK_BITS(256),
                       .SUBBLOCKS(4), .SUB_LOG2(2)) bus ();

  dl2_mem_arbiter #(.NUM_PORTS(NP), .ADDR_BITS(32), .BLOCK_BITS(256),
                    .SUBBLOCKS(4), .SUB_LOG2(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [255:0] mkBlock(input logic [63:0] w0, input logic [63:0] w1,
                                           input logic [63:0] w2, input logic [63:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic pushExp(input logic [2:0] rdy, input logic [255:0] data);
    sbEntry_t e;
    e.rdy  = rdy;
    e.data = data;
    sbQ.push_back(e);
  endtask

  // Completion monitor: every c_ready pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (!reset && (|bus.c_ready)) begin
      if (sbQ.size() == 0) begin
        checkVal("sb_unexpected_ready", {253'd0, bus.c_ready}, 256'd0);
      end else begin
        sbEntry_t e;
        e = sbQ.pop_front();
        checkVal("sb_ready", {253'd0, bus.c_ready}, {253'd0, e.rdy});
        checkVal("sb_dout", bus.c_dout, e.data);
      end
    end
  end

  task automatic serveRead(input logic [31:0] expAddr, input string tag);
    int waitCnt;
    waitCnt = 0;
    while (!bus.enD && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    checkVal({tag, "_enD"}, {255'd0, bus.enD}, 256'd1);
    checkVal({tag, "_addr"}, {224'd0, bus.addrD}, {224'd0, expAddr});
    bus.accR = 1'b0;
    tick();
    checkVal({tag, "_enD_held"}, {255'd0, bus.enD}, 256'd1);
    bus.accR = 1'b1;
    tick();
    bus.accR = 1'b0;
    checkVal({tag, "_enD_drop"}, {255'd0, bus.enD}, 256'd0);
    for (int b = 0; b < nBeats; b++) begin
      bus.readyD     = 1'b1;
      bus.dinDstrobe = beatStrb[b][1:0];
      bus.dinD       = beatData[b];
      tick();
      if (b < nBeats - 1) begin
        checkVal({tag, "_early_ready"}, {253'd0, bus.c_ready}, 256'd0);
      end
    end
    bus.readyD = 1'b0;
  endtask

  task automatic serveWrite(input logic [255:0] blk, input bit everyOther, input string tag);
    int k;
    bit tog;
    k   = 0;
    tog = 1'b0;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      if (bus.weD) begin
        checkVal({tag, "_strobe"}, {254'd0, bus.doutDstrobe}, k);
        checkVal({tag, "_beat"}, {192'd0, bus.doutD}, {192'd0, blk[k*64 +: 64]});
        checkVal({tag, "_no_enD"}, {255'd0, bus.enD}, 256'd0);
        bus.accW = everyOther ? tog : 1'b1;
        if (bus.accW) k++;
        tog = !tog;
      end else begin
        bus.accW = 1'b0;
      end
      tick();
    end
    bus.accW = 1'b0;
    checkVal({tag, "_beats_done"}, k, 256'd4);
  endtask

  function automatic void setInOrderBeats(input logic [63:0] base);
    nBeats = 4;
    for (int s = 0; s < 4; s++) begin
      beatStrb[s] = s;
      beatData[s] = base + 64'(s);
    end
  endfunction

  initial begin
    logic [255:0] blk;
    logic [2:0]   order [4];
    vecCount = 0;
    errCount = 0;
    reset = 1'b1;
    bus.c_addr = '0; bus.c_en = '0; bus.c_we = '0; bus.c_din = '0;
    bus.dinDstrobe = '0; bus.dinD = '0; bus.readyD = 1'b0;
    bus.accR = 1'b0; bus.accW = 1'b0;
    tick();
    checkVal("rst_accepting", {253'd0, bus.c_accepting}, 256'd0);
    checkVal("rst_enD_weD", {254'd0, bus.enD, bus.weD}, 256'd0);
    checkVal("rst_ready", {253'd0, bus.c_ready}, 256'd0);
    reset = 1'b0;
    tick();
    checkVal("idle_accepting", {253'd0, bus.c_accepting}, 256'd7);

    // Single read from client 1, in-order beats A0..A3.
    bus.c_addr[32 +: 32] = 32'h0000_1000;
    bus.c_en = 3'b010;
    pushExp(3'b010, mkBlock(64'hA0, 64'hA1, 64'hA2, 64'hA3));
    tick();
    checkVal("rd_accepting_busy", {253'd0, bus.c_accepting}, 256'd0);
    setInOrderBeats(64'hA0);
    serveRead(32'h0000_1000, "rd1");
    checkVal("rd1_ready_latency", {253'd0, bus.c_ready}, 256'd2);
    bus.c_en = 3'b000;
    tick();

    // Write split from client 0 with accW every other cycle; din changed after grant.
    blk = mkBlock(64'h11, 64'h22, 64'h33, 64'h44);
    bus.c_din[0 +: 256] = blk;
    bus.c_addr[0 +: 32] = 32'h0000_2000;
    bus.c_we = 3'b001;
    pushExp(3'b001, 256'd0);
    tick();
    bus.c_din[0 +: 256] = ~blk;
    serveWrite(blk, 1'b1, "wr0");
    bus.c_we = 3'b000;
    tick();

    // Round robin with all three clients reading continuously, from rr_ptr=0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.c_addr = {32'h300, 32'h200, 32'h100};
    bus.c_en = 3'b111;
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    for (int t = 0; t < 4; t++) begin
      logic [63:0] base;
      logic [31:0] a;
      base = 64'hC0 + 64'(16 * t);
      a = (order[t] == 3'b001) ? 32'h100 : (order[t] == 3'b010) ? 32'h200 : 32'h300;
      pushExp(order[t], mkBlock(base, base + 64'd1, base + 64'd2, base + 64'd3));
      setInOrderBeats(base);
      serveRead(a, "rr");
      tick();
      checkVal("rr_dead_idle", {253'd0, bus.c_accepting}, 256'd7);
    end
    bus.c_en = 3'b000;
    tick();

    // Out-of-order and duplicate beats on client 2: strobes 3,1,1,0,2.
    bus.c_addr[64 +: 32] = 32'h0000_4000;
    bus.c_en = 3'b100;
    nBeats = 5;
    beatStrb[0] = 3; beatData[0] = 64'hD3;
    beatStrb[1] = 1; beatData[1] = 64'hD1A;
    beatStrb[2] = 1; beatData[2] = 64'hD1B;
    beatStrb[3] = 0; beatData[3] = 64'hD0;
    beatStrb[4] = 2; beatData[4] = 64'hD2;
    pushExp(3'b100, mkBlock(64'hD0, 64'hD1B, 64'hD2, 64'hD3));
    tick();
    serveRead(32'h0000_4000, "ooo");
    bus.c_en = 3'b000;
    tick();

    // en and we together on client 1: must be a write, no read request.
    blk = mkBlock(64'h5, 64'h6, 64'h7, 64'h8);
    bus.c_din[256 +: 256] = blk;
    bus.c_en = 3'b010;
    bus.c_we = 3'b010;
    pushExp(3'b010, 256'd0);
    tick();
    checkVal("both_weD", {254'd0, bus.weD, bus.enD}, 256'd2);
    serveWrite(blk, 1'b0, "both");
    bus.c_en = 3'b000;
    bus.c_we = 3'b000;
    tick();

    // Reset during write beat 2, then a fresh client-2 write starting at beat 0.
    blk = mkBlock(64'hB0, 64'hB1, 64'hB2, 64'hB3);
    bus.c_din[0 +: 256] = blk;
    bus.c_we = 3'b001;
    tick();
    bus.accW = 1'b1;
    tick();
    tick();
    checkVal("mid_strobe2", {253'd0, bus.weD, bus.doutDstrobe}, 256'd6);
    reset = 1'b1;
    #1;
    checkVal("mid_rst_weD", {254'd0, bus.weD, bus.enD}, 256'd0);
    bus.accW = 1'b0;
    bus.c_we = 3'b000;
    tick();
    reset = 1'b0;
    tick();
    checkVal("post_rst_accepting", {253'd0, bus.c_accepting}, 256'd7);
    blk = mkBlock(64'hE0, 64'hE1, 64'hE2, 64'hE3);
    bus.c_din[512 +: 256] = blk;
    bus.c_we = 3'b100;
    pushExp(3'b100, 256'd0);
    tick();
    serveWrite(blk, 1'b0, "post_rst_wr");
    bus.c_we = 3'b000;
    tick();
    tick();

    checkVal("sb_drained", sbQ.size(), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/dl2_mem_arbiter.md
Name: dl2_mem_arbiter

Overview:
- Parametrised N-client arbiter placed between several cache clients and the single sub-blocked memory port: the per-core DL2 caches in a multi-core System, or the IL1 refill path plus the DL2.
- Serialises block reads and writes from NUM_PORTS clients onto one downstream port.
- Grants clients in round-robin order.
- Splits each write block into SUBBLOCKS strobed beats and reassembles each read block from strobed beats before returning it to the requesting client.

Parameters:
- NUM_PORTS, 2, number of upstream clients (2..8).
- ADDR_BITS, 32, address width, upstream and downstream.
- BLOCK_BITS, 256, cache block width in bits.
- SUBBLOCKS, 4, beats per block, power of two; beat width is BLOCK_BITS/SUBBLOCKS.
- SUB_LOG2, 2, log2(SUBBLOCKS), width of the strobe index.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- c_addr  in  NUM_PORTS*ADDR_BITS  per-client block address; client i occupies slice [i*ADDR_BITS +: ADDR_BITS].
- c_en  in  NUM_PORTS  per-client read request, level.
- c_we  in  NUM_PORTS  per-client write request, level.
- c_din  in  NUM_PORTS*BLOCK_BITS  per-client write block.
- c_dout  out  BLOCK_BITS  read block, shared by all clients, valid when any c_ready bit is high.
- c_ready  out  NUM_PORTS  one-hot, 1-cycle completion pulse.
- c_accepting  out  NUM_PORTS  bit i = 1 when client i may present a new request.
- addrD  out  ADDR_BITS  downstream address.
- enD  out  1  downstream read request.
- weD  out  1  downstream write request.
- doutDstrobe  out  SUB_LOG2  index of the current write beat.
- doutD  out  BLOCK_BITS/SUBBLOCKS  write beat data.
- dinDstrobe  in  SUB_LOG2  index of the incoming read beat.
- dinD  in  BLOCK_BITS/SUBBLOCKS  read beat data.
- readyD  in  1  incoming read beat valid.
- accR  in  1  downstream accepted the read request.
- accW  in  1  downstream accepted the current write beat.

Behaviour:
- Reset values: all outputs 0; c_accepting is all ones once reset deasserts. State IDLE, rr_ptr=0, beat counter 0.
- States: IDLE, WR, RD_REQ, RD_DATA, RESP.
- IDLE, request detection: request vector r[i] = c_en[i] | c_we[i].
- IDLE, arbitration: grant the first i with r[i]=1 scanning from rr_ptr upward, wrapping modulo NUM_PORTS.
- IDLE, capture: latch gnt, addr, op (write if c_we[gnt], else read; we wins when both are set) and c_din[gnt]. The latch happens in the same cycle as the grant; the next state is WR or RD_REQ.
- WR: weD=1, addrD=latched address, doutDstrobe=beat count, doutD=beat[count].
  - Count advances only on a cycle with accW=1.
  - accW on beat SUBBLOCKS-1 -> RESP.
- RD_REQ: enD=1, addrD=latched address.
  - Held until accR=1, then RD_DATA.
  - enD drops in the cycle after accR.
- RD_DATA: each cycle with readyD=1 writes dinD into block slice dinDstrobe and sets recv[dinDstrobe].
  - Beats may arrive in any order.
  - A repeated strobe overwrites the slice.
  - When the set bits of recv cover all SUBBLOCKS (including the beat arriving this cycle) -> RESP.
- RESP, one cycle: c_ready[gnt]=1. For reads, c_dout = the assembled block; for writes, c_dout=0.
  - rr_ptr <= gnt+1 mod NUM_PORTS; recv cleared; next state IDLE.
- c_accepting[i] = 0 from grant through the RESP cycle for i=gnt, and for other i = (state==IDLE).
- Client contract: hold en/we, addr and din stable until its c_ready pulse. c_din changes after the grant are ignored.
- Minimum latency:
  - Write: 1 (grant) + SUBBLOCKS (beats with accW held high) + 1 (RESP).
  - Read: 1 (grant) + 1 (accR) + SUBBLOCKS beats + 1 (RESP).
- Request drop: deassertion of c_en/c_we after the grant does not abort the transfer; the transfer always completes.
- Grant timing: no new grant is issued in the RESP cycle, so each transaction has one dead IDLE cycle.
- Reset mid-transfer: immediate return to IDLE; enD/weD drop asynchronously; partial data is discarded; rr_ptr returns to 0.
- readyD or accW outside the matching state is ignored.

Test Plan:
- Single read, NUM_PORTS=3, BLOCK_BITS=256, SUBBLOCKS=4: client 1 reads addr 0x1000; memory returns beats 0..3 = 0xA0..0xA3 in order -> enD is high until accR. The block is {..A3,A2,A1,A0}. c_ready=3'b010 arrives exactly 1 cycle after the last beat.
- Write split: client 0 writes a block whose 64-bit words are 0x11,0x22,0x33,0x44; accW is high every other cycle -> doutD/doutDstrobe pairs (0,0x11),(1,0x22),(2,0x33),(3,0x44). Each pair is held until accepted. c_ready=3'b001 follows.
- Round-robin: all three clients request continuously -> grant order 0,1,2,0. No client is granted twice while another is waiting.
- Out-of-order and duplicate read beats: strobes 3,1,1,0,2 with distinct data -> completion only after strobe 2. Slice 1 holds the second value for strobe 1.
- Simultaneous en and we on the same client -> a write is performed and enD never asserts.
- Reset asserted during write beat 2 -> weD=0 in the same cycle. After release, a new client-2 request is granted from rr_ptr=0 with beat count 0.
